datapath_sequencer: RTL and testbench
=====================================

# datapath_sequencer

Instruction-level controller for the 8×16 register file and its A/B operand latches. Each instruction is latched on a `start` pulse, decoded, and then sequenced through register-read, ALU and write-back cycles. The sequencer drives `readnum`, `writenum`, `write`, `loada`, `loadb`, `loadc`, `loads`, `asel`, `vsel`, `shift`, `aluop` and `sximm8`, and reports idle on `w`. It sits between instruction fetch and the register file/ALU datapath.

## Interface

Parameters:
- `DATA_W`, 16, instruction and datapath word width
- `RADDR_W`, 3, register index width (8 registers)

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `s` in 1: start; sampled only in WAIT
- `instr` in DATA_W: instruction, sampled with `s`
- `w` out 1: high when idle in WAIT
- `readnum` out RADDR_W: register read index
- `writenum` out RADDR_W: register write index
- `write` out 1: register-file write strobe
- `loada` out 1: A latch enable
- `loadb` out 1: B latch enable
- `loadc` out 1: C result latch enable
- `loads` out 1: status (Z/N/V) latch enable
- `asel` out 1: 1 forces ALU A operand to 0
- `vsel` out 2: write-back source; 00 = C, 01 = `sximm8`, 1x reserved
- `shift` out 2: shifter control for B
- `aluop` out 2: 00 ADD, 01 SUB, 10 AND, 11 NOT-B
- `sximm8` out DATA_W: sign-extended imm8 of the latched instruction
- `illegal` out 1: trap flag (see Configuration)

## Operation

- Instruction fields: opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0], imm8[7:0].
- Legal opcodes:
  - 110/10 MOV Rn,#imm8
  - 110/00 MOV Rd,Rm{,sh}
  - 101/00 ADD Rd,Rn,Rm
  - 101/01 CMP Rn,Rm
  - 101/10 AND Rd,Rn,Rm
  - 101/11 MVN Rd,Rm
- Instruction register: loads `instr` only when state = WAIT and `s` = 1.
- States: WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, WRITE_REG, TRAP (TRAP exists only when trap is enabled).
- Transitions:
  - WAIT: `s` → DECODE.
  - DECODE: MOV imm → WRITE_IMM; MOV reg or MVN → GET_B; ADD/CMP/AND → GET_A; undefined → TRAP or WAIT.
  - WRITE_IMM → WAIT.
  - GET_A → GET_B.
  - GET_B → ALU.
  - ALU: CMP → WAIT; otherwise → WRITE_REG.
  - WRITE_REG → WAIT.
- Outputs are Moore, decoded from state plus the latched instruction. Any strobe not listed for a state is 0.
  - WAIT: `w`=1.
  - WRITE_IMM: `write`=1, `writenum`=Rn, `vsel`=01.
  - GET_A: `readnum`=Rn, `loada`=1.
  - GET_B: `readnum`=Rm, `loadb`=1.
  - ALU: `shift`=sh, `aluop`=op for 101 instructions and 00 for MOV reg; `asel`=1 for MOV reg; `loadc`=1 except CMP; `loads`=1 only for CMP.
  - WRITE_REG: `write`=1, `writenum`=Rd, `vsel`=00.
- `readnum`/`writenum` are 0 outside their states. `shift`/`aluop` are 0 outside ALU.
- `sximm8` = {{8{imm8[7]}}, imm8}, continuously derived from the instruction register.

## Timing

- Reset values: state WAIT; instruction register 0; `w`=1; `illegal`=0; all strobes, indices, `vsel`, `shift`, `aluop`, `sximm8` = 0.
- Reset mid-instruction: abort immediately, with no `write` issued afterwards.
- Cycles from the `s` sample edge until `w` is high again:
  - MOV imm: 3
  - MOV reg / MVN: 5
  - CMP: 5
  - ADD / AND: 6
- `s` high while busy: ignored; `instr` is not re-latched.
- `s` held high in WAIT: a new instruction starts on the same edge the FSM returns to WAIT… correction: it starts on the first edge after `w` rises. Back-to-back issue with no idle cycle is therefore legal.
- `write` is asserted for exactly one cycle per writing instruction; CMP never asserts `write`.

## Configuration

- `DATAPATH_SEQ_TRAP_EN` defined:
  - An undefined opcode moves DECODE → TRAP.
  - TRAP sets `illegal`=1 and `w`=0, and holds until `reset`.
- Macro undefined:
  - An undefined opcode moves DECODE → WAIT, i.e. a 2-cycle NOP with no strobes.
  - TRAP is not compiled in; `illegal` is tied to 0.

## Structure

- Shared package `datapath_seq_pkg` holds:
  - state enum
  - opcode/op constants
  - `vsel` and `aluop` encodings
  - instruction field bit positions
- Sub-module `datapath_seq_decode`: combinational field extraction and instruction classification (is_movimm, is_movreg, is_alu3, is_cmp, is_mvn, is_undef). The FSM stays in the top module.

## Test plan

- Reset asserted mid-ALU of ADD → all outputs 0, `w`=1 on the same cycle; no `write` after release.
- MOV R3,#-5 (0xD3FB), `s` one cycle → 2 cycles later `write`=1, `writenum`=3, `vsel`=01, `sximm8`=0xFFFB; `w` high at cycle 3.
- ADD R2,R1,R0 sh=01 (0xA148) → GET_A `readnum`=1 `loada`; GET_B `readnum`=0 `loadb`; ALU `shift`=01 `aluop`=00 `loadc`; WRITE_REG `writenum`=2; `w` at cycle 6.
- CMP R4,R5 (0xAC05) → `loads`=1 in ALU, `loadc`=0, no `write`; `w` at cycle 5.
- `s` pulsed again at cycle 2 of an ADD with a different `instr` → ignored; original ADD completes unchanged.
- Opcode 111 → with `DATAPATH_SEQ_TRAP_EN`, `illegal`=1 and `w`=0 until reset; without it, `w`=1 two cycles after `s` with no strobes.

Source files
------------

// File: rtl/datapath_seq_pkg.sv
// Shared types and encodings for the datapath sequencer: state enum,
// opcode/op constants, vsel/aluop encodings and instruction field positions.
`default_nettype none

package datapath_seq_pkg;

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_WRITE_IMM = 3'd2,
    S_GET_A     = 3'd3,
    S_GET_B     = 3'd4,
    S_ALU       = 3'd5,
    S_WRITE_REG = 3'd6
`ifdef DATAPATH_SEQ_TRAP_EN
    ,
    S_TRAP      = 3'd7
`endif
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOVIMM = 2'b10;
  localparam logic [1:0] OP_MOVREG = 2'b00;
  localparam logic [1:0] OP_ADD    = 2'b00;
  localparam logic [1:0] OP_CMP    = 2'b01;
  localparam logic [1:0] OP_AND    = 2'b10;
  localparam logic [1:0] OP_MVN    = 2'b11;

  localparam logic [1:0] VSEL_C   = 2'b00;
  localparam logic [1:0] VSEL_IMM = 2'b01;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_AND  = 2'b10;
  localparam logic [1:0] ALUOP_NOTB = 2'b11;

  localparam int OPC_LSB  = 13;
  localparam int OP_LSB   = 11;
  localparam int RN_LSB   = 8;
  localparam int RD_LSB   = 5;
  localparam int SH_LSB   = 3;
  localparam int RM_LSB   = 0;
  localparam int IMM8_LSB = 0;

endpackage

`default_nettype wire

// File: rtl/datapath_seq_decode.sv
// Combinational field extraction and classification of the latched instruction.
`default_nettype none

module datapath_seq_decode
  import datapath_seq_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 3
) (
  input  logic [DATA_W-1:0]  ir,
  output logic [RADDR_W-1:0] rn,
  output logic [RADDR_W-1:0] rd,
  output logic [RADDR_W-1:0] rm,
  output logic [1:0]         op,
  output logic [1:0]         sh,
  output logic [7:0]         imm8,
  output logic               is_movimm,
  output logic               is_movreg,
  output logic               is_alu3,
  output logic               is_cmp,
  output logic               is_mvn,
  output logic               is_undef
);

  logic [2:0] opcode;

  assign opcode = ir[OPC_LSB +: 3];
  assign op     = ir[OP_LSB +: 2];
  assign rn     = ir[RN_LSB +: RADDR_W];
  assign rd     = ir[RD_LSB +: RADDR_W];
  assign rm     = ir[RM_LSB +: RADDR_W];
  assign sh     = ir[SH_LSB +: 2];
  assign imm8   = ir[IMM8_LSB +: 8];

  assign is_movimm = (opcode == OPC_MOV) && (op == OP_MOVIMM);
  assign is_movreg = (opcode == OPC_MOV) && (op == OP_MOVREG);
  // ADD and AND share the three-operand read/ALU/write-back sequence
  assign is_alu3   = (opcode == OPC_ALU) && ((op == OP_ADD) || (op == OP_AND));
  assign is_cmp    = (opcode == OPC_ALU) && (op == OP_CMP);
  assign is_mvn    = (opcode == OPC_ALU) && (op == OP_MVN);
  assign is_undef  = !(is_movimm || is_movreg || is_alu3 || is_cmp || is_mvn);

endmodule

`default_nettype wire

// File: rtl/datapath_sequencer.sv
// Instruction sequencer for the register file / ALU datapath; registered Moore outputs.
// Define DATAPATH_SEQ_TRAP_EN to trap undefined opcodes instead of treating them as NOPs.
`default_nettype none

module datapath_sequencer
  import datapath_seq_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s,
  input  logic [DATA_W-1:0]  instr,
  output logic               w,
  output logic [RADDR_W-1:0] readnum,
  output logic [RADDR_W-1:0] writenum,
  output logic               write,
  output logic               loada,
  output logic               loadb,
  output logic               loadc,
  output logic               loads,
  output logic               asel,
  output logic [1:0]         vsel,
  output logic [1:0]         shift,
  output logic [1:0]         aluop,
  output logic [DATA_W-1:0]  sximm8,
  output logic               illegal
);

  state_t              state;
  logic [DATA_W-1:0]   ir;
  logic [RADDR_W-1:0]  rn, rd, rm;
  logic [1:0]          op, sh;
  logic [7:0]          imm8;
  logic                is_movimm, is_movreg, is_alu3, is_cmp, is_mvn, is_undef;

  datapath_seq_decode #(
    .DATA_W  (DATA_W),
    .RADDR_W (RADDR_W)
  ) u_decode (
    .ir        (ir),
    .rn        (rn),
    .rd        (rd),
    .rm        (rm),
    .op        (op),
    .sh        (sh),
    .imm8      (imm8),
    .is_movimm (is_movimm),
    .is_movreg (is_movreg),
    .is_alu3   (is_alu3),
    .is_cmp    (is_cmp),
    .is_mvn    (is_mvn),
    .is_undef  (is_undef)
  );

  assign sximm8 = {{(DATA_W-8){imm8[7]}}, imm8};

`ifdef DATAPATH_SEQ_TRAP_EN
  logic illegal_q;
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  // Outputs are registered from the current state, so they trail the state by
  // one cycle; a new start is only accepted once w itself is visible high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_WAIT;
      ir       <= '0;
      w        <= 1'b1;
      readnum  <= '0;
      writenum <= '0;
      write    <= 1'b0;
      loada    <= 1'b0;
      loadb    <= 1'b0;
      loadc    <= 1'b0;
      loads    <= 1'b0;
      asel     <= 1'b0;
      vsel     <= VSEL_C;
      shift    <= '0;
      aluop    <= '0;
`ifdef DATAPATH_SEQ_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      w        <= 1'b0;
      readnum  <= '0;
      writenum <= '0;
      write    <= 1'b0;
      loada    <= 1'b0;
      loadb    <= 1'b0;
      loadc    <= 1'b0;
      loads    <= 1'b0;
      asel     <= 1'b0;
      vsel     <= VSEL_C;
      shift    <= '0;
      aluop    <= '0;
      case (state)
        S_WAIT: begin
          w <= 1'b1;
          if (s && w) begin
            ir    <= instr;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (is_movimm)                 state <= S_WRITE_IMM;
          else if (is_movreg || is_mvn)  state <= S_GET_B;
          else if (is_alu3 || is_cmp)    state <= S_GET_A;
`ifdef DATAPATH_SEQ_TRAP_EN
          else if (is_undef)             state <= S_TRAP;
`endif
          else                           state <= S_WAIT;
        end
        S_WRITE_IMM: begin
          write    <= 1'b1;
          writenum <= rn;
          vsel     <= VSEL_IMM;
          state    <= S_WAIT;
        end
        S_GET_A: begin
          readnum <= rn;
          loada   <= 1'b1;
          state   <= S_GET_B;
        end
        S_GET_B: begin
          readnum <= rm;
          loadb   <= 1'b1;
          state   <= S_ALU;
        end
        S_ALU: begin
          shift <= sh;
          aluop <= is_movreg ? ALUOP_ADD : op;
          asel  <= is_movreg;
          loadc <= !is_cmp;
          loads <= is_cmp;
          state <= is_cmp ? S_WAIT : S_WRITE_REG;
        end
        S_WRITE_REG: begin
          write    <= 1'b1;
          writenum <= rd;
          vsel     <= VSEL_C;
          state    <= S_WAIT;
        end
`ifdef DATAPATH_SEQ_TRAP_EN
        S_TRAP: begin
          illegal_q <= 1'b1;
        end
`endif
        default: state <= S_WAIT;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_datapath_sequencer.sv
// Scoreboard bench for datapath_sequencer: directed instructions, hand-computed output events.
`default_nettype none

module tb_datapath_sequencer;

  typedef struct packed {
    int          cyc;
    logic        w;
    logic [2:0]  rn;
    logic [2:0]  wn;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic [1:0]  vsel;
    logic [1:0]  shift;
    logic [1:0]  aluop;
    logic [15:0] sx;
    logic        ill;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s = 1'b0;
  logic [15:0] instr = '0;
  logic        w, write, loada, loadb, loadc, loads, asel, illegal;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, shift, aluop;
  logic [15:0] sximm8;

  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  ev_t  expq[$];

  datapath_sequencer #(.DATA_W(16), .RADDR_W(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .s        (s),
    .instr    (instr),
    .w        (w),
    .readnum  (readnum),
    .writenum (writenum),
    .write    (write),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .asel     (asel),
    .vsel     (vsel),
    .shift    (shift),
    .aluop    (aluop),
    .sximm8   (sximm8),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t snap(int c);
    ev_t e;
    e = '{c, w, readnum, writenum, write, loada, loadb, loadc, loads, asel,
          vsel, shift, aluop, sximm8, illegal};
    return e;
  endfunction

  task automatic check(string name, ev_t got, ev_t exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // stb = {write, loada, loadb, loadc, loads}
  task automatic ex(int c, logic wv, logic [2:0] rn, logic [2:0] wn, logic [4:0] stb,
                    logic as, logic [1:0] vs, logic [1:0] sh, logic [1:0] op,
                    logic [15:0] sx, logic il);
    expq.push_back('{c, wv, rn, wn, stb[4], stb[3], stb[2], stb[1], stb[0], as,
                     vs, sh, op, sx, il});
  endtask

  // Monitor: an event is any cycle with a strobe high or a change of w/illegal.
  initial begin : monitor
    logic pw, pil;
    ev_t  got, exp;
    pw = 1'b1;
    pil = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && (write || loada || loadb || loadc || loads ||
                     (w !== pw) || (illegal !== pil))) begin
        got = snap(cyc);
        if (expq.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_event: got %h, expected none", got);
        end else begin
          exp = expq.pop_front();
          check("event", got, exp);
        end
      end
      pw = w;
      pil = illegal;
    end
  end

  task automatic issue(input logic [15:0] ins, output int st);
    @(negedge clk);
    s = 1'b1;
    instr = ins;
    st = cyc + 1;
    @(negedge clk);
    s = 1'b0;
  endtask

  task automatic idle_check(string name);
    ev_t exp;
    exp = '{0, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
            2'd0, 2'd0, 2'd0, 16'h0000, 1'b0};
    check(name, snap(0), exp);
  endtask

  initial begin : stim
    int n;
    repeat (3) @(negedge clk);
    idle_check("reset_held");
    reset = 1'b0;
    @(negedge clk);
    idle_check("reset_state");

    // MOV R3,#-5
    issue(16'hD3FB, n);
    ex(n+1, 0, 0, 0, 5'b00000, 0, 2'b00, 2'b00, 2'b00, 16'hFFFB, 0);
    ex(n+2, 0, 0, 3, 5'b10000, 0, 2'b01, 2'b00, 2'b00, 16'hFFFB, 0);
    ex(n+3, 1, 0, 0, 5'b00000, 0, 2'b00, 2'b00, 2'b00, 16'hFFFB, 0);
    repeat (8) @(negedge clk);

    // ADD R2,R1,R0 sh=01
    issue(16'hA148, n);
    ex(n+1, 0, 0, 0, 5'b00000, 0, 2'b00, 2'b00, 2'b00, 16'h0048, 0);
    ex(n+2, 0, 1, 0, 5'b01000, 0, 2'b00, 2'b00, 2'b00, 16'h0048, 0);
    ex(n+3, 0, 0, 0, 5'b00100, 0, 2'b00, 2'b00, 2'b00, 16'h0048, 0);
    ex(n+4, 0, 0, 0, 5'b00010, 0, 2'b00, 2'b01, 2'b00, 16'h0048, 0);
    ex(n+5, 0, 0, 2, 5'b10000, 0, 2'b00, 2'b00, 2'b00, 16'h0048, 0);
    ex(n+6, 1, 0, 0, 5'b00000, 0, 2'b00, 2'b00, 2'b00, 16'h0048, 0);
    repeat (8) @(negedge clk);

    // CMP R4,R5
    issue(16'hAC05, n);
    ex(n+1, 0, 0, 0, 5'b00000, 0, 2'b00, 2'b00, 2'b00, 16'h0005, 0);
    ex(n+2, 0, 4, 0, 5'b01000, 0, 2'b00, 2'b00, 2'b00, 16'h0005, 0);
    ex(n+3, 0, 5, 0, 5'b00100, 0, 2'b00, 2'b00, 2'b00, 16'h0005, 0);
    ex(n+4, 0, 0, 0, 5'b00001, 0, 2'b00, 2'b00, 2'b01, 16'h0005, 0);
    ex(n+5, 1, 0, 0, 5'b00000, 0, 2'b00, 2'b00, 2'b00, 16'h0005, 0);
    repeat (8) @(negedge clk);

    // MOV R1,R2 sh=10
    issue(16'hC032, n);
    ex(n+1, 0, 0, 0, 5'b00000, 0, 2'b00, 2'b00, 2'b00, 16'h0032, 0);
    ex(n+2, 0, 2, 0, 5'b00100, 0, 2'b00, 2'b00, 2'b00, 16'h0032, 0);
    ex(n+3, 0, 0, 0, 5'b00010, 1, 2'b00, 2'b10, 2'b00, 16'h0032, 0);
    ex(n+4, 0, 0, 1, 5'b10000, 0, 2'b00, 2'b00, 2'b00, 16'h0032, 0);
    ex(n+5, 1, 0, 0, 5'b00000, 0, 2'b00, 2'b00, 2'b00, 16'h0032, 0);
    repeat (8) @(negedge clk);

    // MVN R7,R6
    issue(16'hB8E6, n);
    ex(n+1, 0, 0, 0, 5'b00000, 0, 2'b00, 2'b00, 2'b00, 16'hFFE6, 0);
    ex(n+2, 0, 6, 0, 5'b00100, 0, 2'b00, 2'b00, 2'b00, 16'hFFE6, 0);
    ex(n+3, 0, 0, 0, 5'b00010, 0, 2'b00, 2'b00, 2'b11, 16'hFFE6, 0);
    ex(n+4, 0, 0, 7, 5'b10000, 0, 2'b00, 2'b00, 2'b00, 16'hFFE6, 0);
    ex(n+5, 1, 0, 0, 5'b00000, 0, 2'b00, 2'b00, 2'b00, 16'hFFE6, 0);
    repeat (8) @(negedge clk);

    // AND R5,R6,R7 sh=11
    issue(16'hB6BF, n);
    ex(n+1, 0, 0, 0, 5'b00000, 0, 2'b00, 2'b00, 2'b00, 16'hFFBF, 0);
    ex(n+2, 0, 6, 0, 5'b01000, 0, 2'b00, 2'b00, 2'b00, 16'hFFBF, 0);
    ex(n+3, 0, 7, 0, 5'b00100, 0, 2'b00, 2'b00, 2'b00, 16'hFFBF, 0);
    ex(n+4, 0, 0, 0, 5'b00010, 0, 2'b00, 2'b11, 2'b10, 16'hFFBF, 0);
    ex(n+5, 0, 0, 5, 5'b10000, 0, 2'b00, 2'b00, 2'b00, 16'hFFBF, 0);
    ex(n+6, 1, 0, 0, 5'b00000, 0, 2'b00, 2'b00, 2'b00, 16'hFFBF, 0);
    repeat (8) @(negedge clk);

    // ADD with a second s pulse (MOV imm) during cycle 2: must be ignored
    issue(16'hA148, n);
    ex(n+1, 0, 0, 0, 5'b00000, 0, 2'b00, 2'b00, 2'b00, 16'h0048, 0);
    ex(n+2, 0, 1, 0, 5'b01000, 0, 2'b00, 2'b00, 2'b00, 16'h0048, 0);
    ex(n+3, 0, 0, 0, 5'b00100, 0, 2'b00, 2'b00, 2'b00, 16'h0048, 0);
    ex(n+4, 0, 0, 0, 5'b00010, 0, 2'b00, 2'b01, 2'b00, 16'h0048, 0);
    ex(n+5, 0, 0, 2, 5'b10000, 0, 2'b00, 2'b00, 2'b00, 16'h0048, 0);
    ex(n+6, 1, 0, 0, 5'b00000, 0, 2'b00, 2'b00, 2'b00, 16'h0048, 0);
    s = 1'b1;
    instr = 16'hD3FB;
    @(negedge clk);
    s = 1'b0;
    repeat (8) @(negedge clk);

    // Back-to-back: s held high; CMP starts on the first edge after w rises
    @(negedge clk);
    s = 1'b1;
    instr = 16'hD3FB;
    n = cyc + 1;
    ex(n+1, 0, 0, 0, 5'b00000, 0, 2'b00, 2'b00, 2'b00, 16'hFFFB, 0);
    ex(n+2, 0, 0, 3, 5'b10000, 0, 2'b01, 2'b00, 2'b00, 16'hFFFB, 0);
    ex(n+3, 1, 0, 0, 5'b00000, 0, 2'b00, 2'b00, 2'b00, 16'hFFFB, 0);
    ex(n+5, 0, 0, 0, 5'b00000, 0, 2'b00, 2'b00, 2'b00, 16'h0005, 0);
    ex(n+6, 0, 4, 0, 5'b01000, 0, 2'b00, 2'b00, 2'b00, 16'h0005, 0);
    ex(n+7, 0, 5, 0, 5'b00100, 0, 2'b00, 2'b00, 2'b00, 16'h0005, 0);
    ex(n+8, 0, 0, 0, 5'b00001, 0, 2'b00, 2'b00, 2'b01, 16'h0005, 0);
    ex(n+9, 1, 0, 0, 5'b00000, 0, 2'b00, 2'b00, 2'b00, 16'h0005, 0);
    @(negedge clk);
    instr = 16'hAC05;
    repeat (4) @(negedge clk);
    s = 1'b0;
    repeat (8) @(negedge clk);

    // Reset mid-ALU of an ADD: immediate idle, and no write afterwards
    issue(16'hA148, n);
    ex(n+1, 0, 0, 0, 5'b00000, 0, 2'b00, 2'b00, 2'b00, 16'h0048, 0);
    ex(n+2, 0, 1, 0, 5'b01000, 0, 2'b00, 2'b00, 2'b00, 16'h0048, 0);
    ex(n+3, 0, 0, 0, 5'b00100, 0, 2'b00, 2'b00, 2'b00, 16'h0048, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    idle_check("reset_mid_alu");
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    idle_check("after_abort");

    // Undefined opcode 111
    issue(16'hE000, n);
    ex(n+1, 0, 0, 0, 5'b00000, 0, 2'b00, 2'b00, 2'b00, 16'h0000, 0);
`ifdef DATAPATH_SEQ_TRAP_EN
    ex(n+2, 0, 0, 0, 5'b00000, 0, 2'b00, 2'b00, 2'b00, 16'h0000, 1);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    idle_check("trap_cleared_by_reset");
    @(negedge clk);
    reset = 1'b0;
`else
    ex(n+2, 1, 0, 0, 5'b00000, 0, 2'b00, 2'b00, 2'b00, 16'h0000, 0);
`endif
    repeat (8) @(negedge clk);

    while (expq.size() > 0) begin
      ev_t e;
      e = expq.pop_front();
      compared++;
      mismatched++;
      $display("FAIL missing_event: got nothing, expected %h", e);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
